pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/next-PC controller that owns the program counter register and sequences each instruction through fetch and execute. It issues instruction-memory requests with a req/ack handshake, holds the fetched instruction for the datapath, and selects the next PC (sequential, branch, jump or exception vector). It also detects fetch timeouts, misaligned targets and halt. It sits between instruction memory and the single-cycle datapath control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC loaded on any exception
MAX_WAIT, 16, fetch cycles without imem_ack before a timeout exception (range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held high until ack
imem_addr  output  32  fetch address; equals pc while imem_req=1
imem_ack  input  1  memory has accepted the request; imem_rdata is valid this cycle
imem_rdata  input  32  instruction word
instr  output  32  latched instruction for the datapath
instr_valid  output  1  high throughout EXEC
exec_done  input  1  datapath has finished the current instruction; sampled only in EXEC
branch_taken  input  1  branch redirect, qualified by exec_done
branch_target  input  32  branch destination
jump  input  1  jump redirect, qualified by exec_done
jump_target  input  32  jump destination
halt  input  1  halt request, qualified by exec_done
pc  output  32  current PC
pc_plus4  output  32  pc+4, combinational, modulo 2^32
epc  output  32  PC of the faulting instruction
exc_cause  output  2  0=none, 1=fetch timeout, 2=misaligned target
halted  output  1  high in HALT

Behaviour:
- Reset values (asynchronous): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, epc=0, exc_cause=0, halted=0, wait counter=0. imem_req rises on the first clk edge after rst deasserts.
- States are FETCH, EXEC, EXC and HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc. imem_req is registered and drops on the edge after ack.
  - On imem_ack: latch instr=imem_rdata, clear the wait counter, go to EXEC. Minimum fetch latency is 1 cycle from req to EXEC.
  - Without ack, the wait counter increments each cycle. When the counter reaches MAX_WAIT: epc=pc, exc_cause=1, go to EXC.
  - An ack arriving in the same cycle the counter reaches MAX_WAIT wins: no exception.
- EXEC:
  - instr_valid=1. The block waits indefinitely for exec_done.
  - On exec_done, apply the first matching rule:
    - halt=1: go to HALT; pc is unchanged.
    - jump=1: next = jump_target.
    - branch_taken=1: next = branch_target.
    - Otherwise: next = pc_plus4.
  - If next[1:0]!=0: epc=pc, exc_cause=2, go to EXC; pc is unchanged.
  - Otherwise: pc=next, go to FETCH.
  - instr_valid drops on the edge that leaves EXEC.
- EXC: one cycle. pc=EXC_VECTOR, then go to FETCH. epc and exc_cause hold until the next exception or reset; exc_cause is not cleared by later good fetches.
- HALT: absorbing state. imem_req=0, instr_valid=0, halted=1. Only rst exits.
- Wrap-around: pc=32'hFFFF_FFFC advances sequentially to 32'h0000_0000 with no exception.
- Reset mid-operation: asserting rst in any state immediately clears all state. A pending memory request is abandoned; the imem side must tolerate req dropping without ack.
- Control inputs are ignored outside EXEC. imem_ack is ignored outside FETCH.

Test Plan:
- Reset, then ack every request on its first cycle with rdata=32'h2000_0001 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses once per instruction; pc_plus4=0x4 at pc=0x0.
- At pc=0x10: exec_done with jump=1, jump_target=0x40 and branch_taken=1, branch_target=0x80 in the same cycle -> next fetch address 0x40 (jump priority).
- With MAX_WAIT=16, withhold ack at pc=0x24 -> exception after 16 wait cycles: epc=0x24, exc_cause=1, next fetch at 0x80. A second run with ack on exactly the 16th cycle -> no exception.
- exec_done with branch_taken=1, branch_target=0x102 at pc=0x50 -> epc=0x50, exc_cause=2, pc becomes 0x80, next fetch 0x80.
- Force pc=0xFFFF_FFFC via jump_target, then complete that instruction without a redirect -> next fetch address 0x0000_0000, exc_cause unchanged.
- exec_done with halt=1 at pc=0x8 -> halted=1 and pc stays 0x8, no imem_req for 20 cycles. Assert rst mid-fetch at pc=0xC -> pc=0x0 and imem_req=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches over req/ack (min 1 cycle req->EXEC), holds instr until exec_done, then picks the next PC.
// Backpressure: imem_req is held until imem_ack or a MAX_WAIT timeout; EXEC stalls indefinitely until exec_done.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_EXC, S_HALT} state_t;

    // wait_cnt holds the number of unacked request cycles already seen
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = branch_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            epc         <= 32'd0;
            exc_cause   <= 2'd0;
            halted      <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        // ack beats a timeout landing in the same cycle
                        instr       <= imem_rdata;
                        wait_cnt    <= 8'd0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        epc       <= pc;
                        exc_cause <= 2'd1;
                        wait_cnt  <= 8'd0;
                        imem_req  <= 1'b0;
                        state     <= S_EXC;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (next_pc[1:0] != 2'b00) begin
                            epc       <= pc;
                            exc_cause <= 2'd2;
                            state     <= S_EXC;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_EXC: begin
                    pc       <= EXC_VECTOR;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written halt, async reset and fetch timeout sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic [1:0]  exc_cause;
    logic        halted;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RD = 32'h2000_0001;

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080),
        .MAX_WAIT   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .exc_cause     (exc_cause),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        done;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        hlt;
        logic        e_req;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [1:0]  e_cause;
        logic [31:0] e_epc;
        logic        e_halt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic ack, logic done, logic jmp, logic [31:0] jt,
                                logic br, logic [31:0] bt, logic hlt,
                                logic e_req, logic e_vld, logic [31:0] e_pc,
                                logic [1:0] e_cause, logic [31:0] e_epc, logic e_halt);
        vec_t v;
        v.ack = ack; v.done = done; v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt; v.hlt = hlt;
        v.e_req = e_req; v.e_vld = e_vld; v.e_pc = e_pc;
        v.e_cause = e_cause; v.e_epc = e_epc; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setin(input logic ack, input logic done, input logic jmp,
                         input logic [31:0] jt, input logic hlt);
        imem_ack      = ack;
        exec_done     = done;
        jump          = jmp;
        jump_target   = jt;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        halt          = hlt;
    endtask

    // leaves the bench at a negedge with rst low and the DUT in its reset state
    task automatic do_reset();
        setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        imem_rdata = RD;
        setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        tbl[0]  = mk(0,0,0,32'h0,0,32'h0,0,         0,0,32'h0,0,32'h0,0);
        tbl[1]  = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h0,0,32'h0,0);
        tbl[2]  = mk(1,1,0,32'h0,0,32'h0,0,         0,1,32'h0,0,32'h0,0);
        tbl[3]  = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h4,0,32'h0,0);
        tbl[4]  = mk(0,1,0,32'h0,0,32'h0,0,         0,1,32'h4,0,32'h0,0);
        tbl[5]  = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h8,0,32'h0,0);
        tbl[6]  = mk(0,1,0,32'h0,0,32'h0,0,         0,1,32'h8,0,32'h0,0);
        tbl[7]  = mk(0,1,1,32'h200,0,32'h0,0,       1,0,32'hC,0,32'h0,0);
        tbl[8]  = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'hC,0,32'h0,0);
        tbl[9]  = mk(0,1,1,32'h10,0,32'h0,0,        0,1,32'hC,0,32'h0,0);
        tbl[10] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h10,0,32'h0,0);
        tbl[11] = mk(0,1,1,32'h40,1,32'h80,0,       0,1,32'h10,0,32'h0,0);
        tbl[12] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h40,0,32'h0,0);
        tbl[13] = mk(0,1,1,32'h50,0,32'h0,0,        0,1,32'h40,0,32'h0,0);
        tbl[14] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h50,0,32'h0,0);
        tbl[15] = mk(0,1,0,32'h0,1,32'h102,0,       0,1,32'h50,0,32'h0,0);
        tbl[16] = mk(0,0,0,32'h0,0,32'h0,0,         0,0,32'h50,2,32'h50,0);
        tbl[17] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h80,2,32'h50,0);
        tbl[18] = mk(0,1,1,32'hFFFF_FFFC,0,32'h0,0, 0,1,32'h80,2,32'h50,0);
        tbl[19] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'hFFFF_FFFC,2,32'h50,0);
        tbl[20] = mk(0,1,0,32'h0,0,32'h0,0,         0,1,32'hFFFF_FFFC,2,32'h50,0);
        tbl[21] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h0,2,32'h50,0);
        tbl[22] = mk(0,1,1,32'h8,0,32'h0,0,         0,1,32'h0,2,32'h50,0);
        tbl[23] = mk(1,0,0,32'h0,0,32'h0,0,         1,0,32'h8,2,32'h50,0);
        tbl[24] = mk(0,1,1,32'h300,0,32'h0,1,       0,1,32'h8,2,32'h50,0);
        tbl[25] = mk(0,0,0,32'h0,0,32'h0,0,         0,0,32'h8,2,32'h50,1);

        do_reset();
        chk("reset_instr", instr, 32'd0);

        // each row: outputs are checked for the current cycle, inputs act on the next edge
        for (int i = 0; i < 26; i++) begin
            imem_ack      = tbl[i].ack;
            exec_done     = tbl[i].done;
            jump          = tbl[i].jmp;
            jump_target   = tbl[i].jt;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].bt;
            halt          = tbl[i].hlt;
            chk($sformatf("row%0d_req", i),    {31'd0, imem_req},    {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d_vld", i),    {31'd0, instr_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("row%0d_pc", i),     pc,                   tbl[i].e_pc);
            chk($sformatf("row%0d_pc4", i),    pc_plus4,             tbl[i].e_pc + 32'd4);
            chk($sformatf("row%0d_cause", i),  {30'd0, exc_cause},   {30'd0, tbl[i].e_cause});
            chk($sformatf("row%0d_epc", i),    epc,                  tbl[i].e_epc);
            chk($sformatf("row%0d_halted", i), {31'd0, halted},      {31'd0, tbl[i].e_halt});
            if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_pc);
            if (tbl[i].e_vld) chk($sformatf("row%0d_instr", i), instr, RD);
            @(negedge clk);
        end

        // HALT must absorb acks and control inputs
        for (int k = 0; k < 20; k++) begin
            setin(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
            chk($sformatf("halt%0d_req", k),    {31'd0, imem_req},    32'd0);
            chk($sformatf("halt%0d_halted", k), {31'd0, halted},      32'd1);
            chk($sformatf("halt%0d_pc", k),     pc,                   32'h8);
            chk($sformatf("halt%0d_vld", k),    {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end

        // asynchronous reset during a pending fetch at 0xC
        do_reset();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        setin(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        setin(1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
        @(negedge clk);
        setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        chk("midfetch_addr", imem_addr, 32'hC);
        #2 rst = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // fetch timeout at 0x24, then a run acked on exactly the last allowed cycle
        @(negedge clk);
        setin(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        setin(1'b0, 1'b1, 1'b1, 32'h24, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            chk($sformatf("to_wait%0d_req", k),   {31'd0, imem_req},  32'd1);
            chk($sformatf("to_wait%0d_cause", k), {30'd0, exc_cause}, 32'd0);
            @(negedge clk);
        end
        chk("to_epc",   epc,                32'h24);
        chk("to_cause", {30'd0, exc_cause}, 32'd1);
        chk("to_req",   {31'd0, imem_req},  32'd0);
        @(negedge clk);
        chk("to_vec_req",  {31'd0, imem_req}, 32'd1);
        chk("to_vec_addr", imem_addr,         32'h80);
        setin(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        setin(1'b0, 1'b1, 1'b1, 32'h24, 1'b0);
        @(negedge clk);
        imem_rdata = 32'h1234_5678;
        for (int k = 1; k <= 16; k++) begin
            setin(k == 16, 1'b0, 1'b0, 32'd0, 1'b0);
            chk($sformatf("late%0d_req", k), {31'd0, imem_req}, 32'd1);
            @(negedge clk);
        end
        setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("late_vld",   {31'd0, instr_valid}, 32'd1);
        chk("late_instr", instr,                32'h1234_5678);
        chk("late_pc",    pc,                   32'h24);
        chk("late_cause", {30'd0, exc_cause},   32'd1);
        chk("late_epc",   epc,                  32'h24);
        setin(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        setin(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("late_next_addr", imem_addr,          32'h28);
        chk("late_next_req",  {31'd0, imem_req},  32'd1);
        chk("late_next_vld",  {31'd0, instr_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
